// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-side bus of the shared memory port.
// The arbiter connects through the slave modport; requesters and memory use master.
interface mem_bus_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic                      resp_err;
  logic [DATA_W-1:0]         resp_rdata;
  logic [TAG_W-1:0]          resp_tag;
  logic                      mem_read;
  logic                      mem_write;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_rvalid;
  logic [DATA_W-1:0]         mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata, resp_tag,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, resp_tag,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters,
// one transaction in flight, with a bounded wait for read data.
module mem_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_bus_arbiter_if.slave   bus
);
  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  state_t              state_reg, state_next;
  logic [OWN_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [OWN_W-1:0]    owner_reg, owner_next;
  logic                write_reg, write_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [7:0]          wait_cnt_reg, wait_cnt_next;

  logic [NUM_REQ-1:0]  req_ready_reg, req_ready_next;
  logic [NUM_REQ-1:0]  resp_valid_reg, resp_valid_next;
  logic                resp_err_reg, resp_err_next;
  logic [DATA_W-1:0]   resp_rdata_reg, resp_rdata_next;
  logic [TAG_W-1:0]    resp_tag_reg, resp_tag_next;
  logic                mem_read_reg, mem_read_next;
  logic                mem_write_reg, mem_write_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;

  logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]  req_rot;
  logic                grant_found;
  logic [OWN_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0]  owner_onehot;
  logic                timed_out;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = bus.req_wdata[gi*DATA_W +: DATA_W];
  end

  // Rotating the doubled request vector puts rr_ptr at bit 0, so the lowest
  // set bit of req_rot is the round-robin winner.
  assign req_dbl = {bus.req_valid, bus.req_valid};
  assign req_rot = req_dbl[rr_ptr_reg +: NUM_REQ];

  always_comb begin
    int s;
    s           = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        s = int'(rr_ptr_reg) + i;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        grant_found = 1'b1;
        grant_idx   = OWN_W'(s);
      end
    end
  end

  assign owner_onehot = NUM_REQ'(1) << owner_reg;
  assign timed_out    = (wait_cnt_reg == 8'(TIMEOUT - 1));

  always_comb begin
    state_next      = state_reg;
    rr_ptr_next     = rr_ptr_reg;
    owner_next      = owner_reg;
    write_next      = write_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    wait_cnt_next   = wait_cnt_reg;
    req_ready_next  = '0;
    resp_valid_next = '0;
    resp_err_next   = resp_err_reg;
    resp_rdata_next = resp_rdata_reg;
    resp_tag_next   = resp_tag_reg;
    mem_read_next   = 1'b0;
    mem_write_next  = 1'b0;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;

    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          owner_next     = grant_idx;
          write_next     = bus.req_write[grant_idx];
          addr_next      = addr_arr[grant_idx];
          wdata_next     = wdata_arr[grant_idx];
          req_ready_next = NUM_REQ'(1) << grant_idx;
          state_next     = ISSUE;
        end
      end

      ISSUE: begin
        mem_addr_next  = addr_reg;
        mem_wdata_next = wdata_reg;
        if (write_reg) begin
          mem_write_next = 1'b1;
          state_next     = RESP;
        end else begin
          mem_read_next  = 1'b1;
          wait_cnt_next  = '0;
          state_next     = WAIT_RD;
        end
      end

      // Read completion is registered on the way into RESP so that a
      // 1-cycle memory gives resp_valid two cycles after mem_read.
      WAIT_RD: begin
        if (bus.mem_rvalid) begin
          resp_valid_next = owner_onehot;
          resp_err_next   = 1'b0;
          resp_rdata_next = bus.mem_rdata;
          resp_tag_next   = addr_reg[ADDR_W-1 -: TAG_W];
          state_next      = RESP;
        end else if (timed_out) begin
          resp_valid_next = owner_onehot;
          resp_err_next   = 1'b1;
          resp_rdata_next = '0;
          resp_tag_next   = addr_reg[ADDR_W-1 -: TAG_W];
          state_next      = RESP;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end

      RESP: begin
        if (write_reg) begin
          resp_valid_next = owner_onehot;
          resp_err_next   = 1'b0;
          resp_tag_next   = addr_reg[ADDR_W-1 -: TAG_W];
        end
        rr_ptr_next = (owner_reg == OWN_W'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;
        state_next  = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      owner_reg      <= '0;
      write_reg      <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wait_cnt_reg   <= '0;
      req_ready_reg  <= '0;
      resp_valid_reg <= '0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
      resp_tag_reg   <= '0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      rr_ptr_reg     <= rr_ptr_next;
      owner_reg      <= owner_next;
      write_reg      <= write_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      wait_cnt_reg   <= wait_cnt_next;
      req_ready_reg  <= req_ready_next;
      resp_valid_reg <= resp_valid_next;
      resp_err_reg   <= resp_err_next;
      resp_rdata_reg <= resp_rdata_next;
      resp_tag_reg   <= resp_tag_next;
      mem_read_reg   <= mem_read_next;
      mem_write_reg  <= mem_write_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
    end
  end

  assign bus.req_ready  = req_ready_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_err   = resp_err_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign bus.resp_tag   = resp_tag_reg;
  assign bus.mem_read   = mem_read_reg;
  assign bus.mem_write  = mem_write_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_wdata  = mem_wdata_reg;
endmodule
